// File: rtl/step_sequencer.sv
// step_sequencer: upstream sequencing stage of the simple processor.
// Fetches an instruction word into ir and steps a 2-bit counter that feeds
// the control unit. The control unit's clear ends the instruction, which
// raises a one-cycle done pulse and bumps the retired-instruction counter.
// Optional feature macro: STEP_SEQUENCER_TIMEOUT_EN. When it is defined, an
// instruction still running at count==3 with no clear is aborted, and a
// one-cycle abort pulse is raised. Otherwise count holds at 3 and abort is 0.
module step_sequencer #(
    parameter int IW = 9,
    parameter int RW = 16
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          run,
    input  logic [IW-1:0] din,
    input  logic          clear,
    output logic [IW-1:0] ir,
    output logic [1:0]    count,
    output logic          busy,
    output logic          done,
    output logic          abort,
    output logic [RW-1:0] retired
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] ir_q, ir_d;
    logic [1:0]    count_q, count_d;
    logic          done_q, done_d;
    logic [RW-1:0] retired_q, retired_d;
`ifdef STEP_SEQUENCER_TIMEOUT_EN
    logic          abort_q, abort_d;
`endif

    // Next-state decode for the IDLE/EXEC sequencer and its registered outputs.
    always_comb begin
        // NOTE: every _d gets a default before the case, so no path leaves a
        // signal unassigned and no latch is inferred.
        state_d   = state_q;
        ir_d      = ir_q;
        count_d   = count_q;
        retired_d = retired_q;
        done_d    = 1'b0;
`ifdef STEP_SEQUENCER_TIMEOUT_EN
        abort_d   = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                // clear is ignored here; only run starts an instruction.
                if (run) begin
                    ir_d    = din;
                    count_d = 2'd1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // clear takes priority, and run is never sampled in EXEC,
                // so ir stays stable for the whole instruction.
                if (clear) begin
                    count_d   = 2'd0;
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    retired_d = retired_q + RW'(1);
                end else if (count_q != 2'd3) begin
                    count_d = count_q + 2'd1;
                end else begin
`ifdef STEP_SEQUENCER_TIMEOUT_EN
                    count_d = 2'd0;
                    state_d = ST_IDLE;
                    abort_d = 1'b1;
`else
                    count_d = count_q;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = 2'd0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge value of its neighbours.
        if (!resetn) begin
            // NOTE: ir is a plain register, not a memory, and the control unit
            // decodes it directly, so it is cleared on reset with the rest.
            state_q   <= ST_IDLE;
            ir_q      <= '0;
            count_q   <= 2'd0;
            done_q    <= 1'b0;
            retired_q <= '0;
`ifdef STEP_SEQUENCER_TIMEOUT_EN
            abort_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            count_q   <= count_d;
            done_q    <= done_d;
            retired_q <= retired_d;
`ifdef STEP_SEQUENCER_TIMEOUT_EN
            abort_q   <= abort_d;
`endif
        end
    end

    assign ir      = ir_q;
    assign count   = count_q;
    assign busy    = (state_q == ST_EXEC);
    assign done    = done_q;
    assign retired = retired_q;
`ifdef STEP_SEQUENCER_TIMEOUT_EN
    assign abort   = abort_q;
`else
    assign abort   = 1'b0;
`endif

endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: directed bench for step_sequencer.
// A second instance with RW=2 shares every input, so its retired counter
// wraps after four completions and exercises the modulo-2^RW rollover.
// Expected values follow STEP_SEQUENCER_TIMEOUT_EN when it is defined.
module tb_step_sequencer;

    logic        clock;
    logic        resetn;
    logic        run;
    logic [8:0]  din;
    logic        clear;
    logic [8:0]  ir;
    logic [1:0]  count;
    logic        busy;
    logic        done;
    logic        abort;
    logic [15:0] retired;

    logic [8:0]  ir_w;
    logic [1:0]  count_w;
    logic        busy_w;
    logic        done_w;
    logic        abort_w;
    logic [1:0]  retired_w;

    int vectors;
    int miscompares;

    step_sequencer #(.IW(9), .RW(16)) dut (
        .clock   (clock),
        .resetn  (resetn),
        .run     (run),
        .din     (din),
        .clear   (clear),
        .ir      (ir),
        .count   (count),
        .busy    (busy),
        .done    (done),
        .abort   (abort),
        .retired (retired)
    );

    step_sequencer #(.IW(9), .RW(2)) dut_w (
        .clock   (clock),
        .resetn  (resetn),
        .run     (run),
        .din     (din),
        .clear   (clear),
        .ir      (ir_w),
        .count   (count_w),
        .busy    (busy_w),
        .done    (done_w),
        .abort   (abort_w),
        .retired (retired_w)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        resetn = 1'b0;
        run    = 1'b0;
        din    = 9'h000;
        clear  = 1'b0;
        step();
        step();
        check("rst_ir", ir, 0);
        check("rst_count", count, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_abort", abort, 0);
        check("rst_retired", retired, 0);
        resetn = 1'b1;

        // Reset mid-instruction.
        din = 9'h1A5; run = 1'b1;
        step();
        check("mid_fetch_ir", ir, 9'h1A5);
        check("mid_fetch_count", count, 1);
        check("mid_fetch_busy", busy, 1);
        run = 1'b0;
        step();
        check("mid_count2", count, 2);
        resetn = 1'b0;
        step();
        check("mid_rst_ir", ir, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_retired", retired, 0);
        resetn = 1'b1;
        step();
        check("mid_idle_count", count, 0);

        // Single instruction, clear at count=2.
        din = 9'h040; run = 1'b1;
        step();
        check("single_ir", ir, 9'h040);
        check("single_c1", count, 1);
        check("single_busy", busy, 1);
        check("single_done0", done, 0);
        run = 1'b0; din = 9'h000;
        step();
        check("single_c2", count, 2);
        clear = 1'b1;
        step();
        check("single_c0", count, 0);
        check("single_busy0", busy, 0);
        check("single_done", done, 1);
        check("single_retired", retired, 1);
        check("single_ir_hold", ir, 9'h040);
        clear = 1'b0;
        step();
        check("single_done_pulse", done, 0);
        check("single_retired_hold", retired, 1);

        // clear while idle is ignored.
        clear = 1'b1;
        step();
        check("idle_clear_busy", busy, 0);
        check("idle_clear_done", done, 0);
        check("idle_clear_retired", retired, 1);
        clear = 1'b0;

        // Back-to-back with run held, clear at count=1.
        din = 9'h011; run = 1'b1;
        step();
        check("b2b_ir1", ir, 9'h011);
        check("b2b_busy1", busy, 1);
        check("b2b_count1", count, 1);
        clear = 1'b1; din = 9'h022;
        step();
        check("b2b_busy0", busy, 0);
        check("b2b_done1", done, 1);
        check("b2b_retired1", retired, 2);
        check("b2b_ir_nofetch", ir, 9'h011);
        clear = 1'b0;
        step();
        check("b2b_ir2", ir, 9'h022);
        check("b2b_busy2", busy, 1);
        check("b2b_count2", count, 1);
        check("b2b_done_low", done, 0);
        clear = 1'b1;
        step();
        check("b2b_busy3", busy, 0);
        check("b2b_done2", done, 1);
        check("b2b_retired2", retired, 3);
        run = 1'b0; clear = 1'b0;
        step();
        check("b2b_idle", busy, 0);
        check("b2b_done_end", done, 0);

        // run ignored while busy; clear at count=3 completes normally.
        din = 9'h0F0; run = 1'b1;
        step();
        check("ign_ir1", ir, 9'h0F0);
        din = 9'h1FF;
        step();
        check("ign_ir2", ir, 9'h0F0);
        check("ign_count2", count, 2);
        step();
        check("ign_ir3", ir, 9'h0F0);
        check("ign_count3", count, 3);
        clear = 1'b1;
        step();
        check("ign_done", done, 1);
        check("ign_retired", retired, 4);
        check("ign_count0", count, 0);
        check("ign_ir_end", ir, 9'h0F0);
        check("wrap_retired_w", retired_w, 0);
        check("wrap_done_w", done_w, 1);
        run = 1'b0; clear = 1'b0;
        step();

        // Timeout: fetch and never clear.
        din = 9'h055; run = 1'b1;
        step();
        check("to_c1", count, 1);
        run = 1'b0;
        step();
        check("to_c2", count, 2);
        step();
        check("to_c3", count, 3);
        step();
`ifdef STEP_SEQUENCER_TIMEOUT_EN
        check("to_c0", count, 0);
        check("to_busy0", busy, 0);
        check("to_abort", abort, 1);
        check("to_done0", done, 0);
        check("to_retired", retired, 4);
        step();
        check("to_abort_pulse", abort, 0);
        check("to_retired_hold", retired, 4);
`else
        check("hold_c3_a", count, 3);
        check("hold_busy", busy, 1);
        check("hold_abort", abort, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("hold_c3", count, 3);
        end
        clear = 1'b1;
        step();
        check("hold_done", done, 1);
        check("hold_retired", retired, 5);
        check("hold_c0", count, 0);
        check("hold_retired_w", retired_w, 1);
        clear = 1'b0;
        step();
        check("hold_done_pulse", done, 0);
`endif

        // Reset with a nonzero retired count and run asserted.
        din = 9'h1A5; run = 1'b1;
        step();
        check("rst2_busy_pre", busy, 1);
        resetn = 1'b0;
        step();
        check("rst2_ir", ir, 0);
        check("rst2_busy", busy, 0);
        check("rst2_count", count, 0);
        check("rst2_retired", retired, 0);
        check("rst2_retired_w", retired_w, 0);
        resetn = 1'b1; run = 1'b0;
        step();
        check("rst2_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
